// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, parameter limits, helpers.
package rst_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET = 3'd0,
        ST_HOLD  = 3'd1,
        ST_SEQ   = 3'd2,
        ST_RUN   = 3'd3,
        ST_SWRST = 3'd4
    } state_e;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;
    localparam int unsigned N_OUT_MIN       = 1;
    localparam int unsigned N_OUT_MAX       = 16;
    localparam int unsigned HOLD_CYCLES_MIN = 1;
    localparam int unsigned STEP_CYCLES_MIN = 1;
    localparam int unsigned SW_PULSE_MIN    = 1;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Bus between the reset sequencer and its environment: software request in, reset fan-out and status out.
interface rst_seq_if #(
    parameter int unsigned N_OUT = 4
);
    logic                               i_sw_rst_req;
    logic [N_OUT-1:0]                   o_rst;
    logic                               o_ready;
    logic [rst_seq_pkg::STATE_W-1:0]    o_state;

    modport master (
        output i_sw_rst_req,
        input  o_rst,
        input  o_ready,
        input  o_state
    );

    modport slave (
        input  i_sw_rst_req,
        output o_rst,
        output o_ready,
        output o_state
    );
endinterface

// File: rtl/rst_sync.sv
// Async-assert / sync-release flop chain; output rises SYNC_STAGES edges after reset release.
module rst_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic synced
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign synced = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Power-on reset sequencer: releases N_OUT reset domains in order after a synchronised board reset.
// Optional software reset re-sequencing is enabled with macro RST_SEQ_SW_RESET_EN.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned N_OUT       = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STEP_CYCLES = 8,
    parameter int unsigned SW_PULSE    = 4
) (
    input  logic      i_brd_clk,
    input  logic      i_reset_n,
    rst_seq_if.slave  bus
);

    localparam int unsigned CNT_MAX = max3(HOLD_CYCLES, STEP_CYCLES, SW_PULSE);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX ||
        N_OUT < N_OUT_MIN || N_OUT > N_OUT_MAX ||
        HOLD_CYCLES < HOLD_CYCLES_MIN || STEP_CYCLES < STEP_CYCLES_MIN ||
        SW_PULSE < SW_PULSE_MIN) begin : g_param_check
        $error("rst_sequencer: parameter outside legal range");
    end

    logic             synced;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [N_OUT-1:0] rst_q, rst_d;
    logic [N_OUT-1:0] rst_shift;
    logic             ready_q, ready_d;
    logic             sw_req_fire;

    rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk    (i_brd_clk),
        .rst_n  (i_reset_n),
        .synced (synced)
    );

`ifdef RST_SEQ_SW_RESET_EN
    // Rising-edge detect so a held request produces a single SWRST entry.
    logic sw_req_prev_q, sw_req_prev_d;

    always_comb begin
        sw_req_prev_d = bus.i_sw_rst_req;
        sw_req_fire   = bus.i_sw_rst_req & ~sw_req_prev_q;
    end

    always_ff @(posedge i_brd_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sw_req_prev_q <= 1'b0;
        end else begin
            sw_req_prev_q <= sw_req_prev_d;
        end
    end
`else
    logic unused_sw_req;
    assign unused_sw_req = bus.i_sw_rst_req;
    assign sw_req_fire   = 1'b0;
`endif

    // Saturating increment; the counter never wraps.
    assign cnt_inc   = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
    assign rst_shift = rst_q << 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        ready_d = ready_q;

        case (state_q)
            ST_RESET: begin
                rst_d   = '1;
                ready_d = 1'b0;
                cnt_d   = '0;
                if (synced) begin
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    cnt_d = '0;
                    rst_d = rst_shift;
                    if (rst_shift == '0) begin
                        ready_d = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_SEQ;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            // Each step clears the lowest still-asserted bit; last bit doubles as ready.
            ST_SEQ: begin
                if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
                    cnt_d = '0;
                    rst_d = rst_shift;
                    if (rst_shift == '0) begin
                        ready_d = 1'b1;
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_RUN: begin
                cnt_d = '0;
                if (sw_req_fire) begin
                    rst_d   = '1;
                    ready_d = 1'b0;
                    state_d = ST_SWRST;
                end
            end

`ifdef RST_SEQ_SW_RESET_EN
            ST_SWRST: begin
                if (cnt_q == CNT_W'(SW_PULSE - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif

            default: begin
                rst_d   = '1;
                ready_d = 1'b0;
                cnt_d   = '0;
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge i_brd_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
        end
    end

    assign bus.o_rst   = rst_q;
    assign bus.o_ready = ready_q;
    assign bus.o_state = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench: two sequencer configurations against a timeline model of release edges.
module tb_rst_sequencer;

`ifdef RST_SEQ_SW_RESET_EN
    localparam bit SW_EN = 1'b1;
`else
    localparam bit SW_EN = 1'b0;
`endif

    // Configuration A: defaults. Configuration B: single output, deeper sync, minimum hold.
    localparam int SY_A = 2, N_A = 4, H_A = 16, S_A = 8, SW_A = 4;
    localparam int SY_B = 3, N_B = 1, H_B = 1,  S_B = 8;

    logic clk = 1'b0;
    logic rst_n;

    rst_seq_if #(.N_OUT(N_A)) bus_a ();
    rst_seq_if #(.N_OUT(N_B)) bus_b ();

    rst_sequencer #(
        .SYNC_STAGES (SY_A), .N_OUT (N_A), .HOLD_CYCLES (H_A),
        .STEP_CYCLES (S_A), .SW_PULSE (SW_A)
    ) u_dut_a (
        .i_brd_clk (clk),
        .i_reset_n (rst_n),
        .bus       (bus_a)
    );

    rst_sequencer #(
        .SYNC_STAGES (SY_B), .N_OUT (N_B), .HOLD_CYCLES (H_B),
        .STEP_CYCLES (S_B), .SW_PULSE (4)
    ) u_dut_b (
        .i_brd_clk (clk),
        .i_reset_n (rst_n),
        .bus       (bus_b)
    );

    always #5 clk = ~clk;

    int cyc;
    int t0a, t0b, swa;
    bit req_prev;
    int n_tests, n_fail;

    // Timeline model: everything is a function of the edge count relative to T0.
    function automatic int st_exp(int c, int t0, int sws, int h, int s, int n);
        int k;
        if (t0 < 0) return 0;
        if (c < t0) return (sws >= 0 && c >= sws) ? 4 : 0;
        k = c - t0;
        if (k < h) return 1;
        if (k < h + (n - 1) * s) return 2;
        return 3;
    endfunction

    function automatic logic [15:0] rst_exp(int c, int t0, int h, int s, int n);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            r[i] = (t0 < 0) || (c < t0) || ((c - t0) < h + i * s);
        end
        return r;
    endfunction

    function automatic logic rdy_exp(int c, int t0, int h, int s, int n);
        return (t0 >= 0) && (c >= t0) && ((c - t0) >= h + (n - 1) * s);
    endfunction

    task automatic check_all(input string tag);
        logic [15:0] ea, eb;
        logic [2:0]  sa, sb;
        logic        ra, rb;
        ea = rst_exp(cyc, t0a, H_A, S_A, N_A);
        eb = rst_exp(cyc, t0b, H_B, S_B, N_B);
        sa = 3'(st_exp(cyc, t0a, swa, H_A, S_A, N_A));
        sb = 3'(st_exp(cyc, t0b, -1, H_B, S_B, N_B));
        ra = rdy_exp(cyc, t0a, H_A, S_A, N_A);
        rb = rdy_exp(cyc, t0b, H_B, S_B, N_B);

        n_tests++;
        assert (bus_a.o_rst === ea[3:0]) else begin
            n_fail++;
            $error("FAIL %s a.o_rst cyc=%0d got=%b exp=%b", tag, cyc, bus_a.o_rst, ea[3:0]);
        end
        n_tests++;
        assert (bus_a.o_ready === ra) else begin
            n_fail++;
            $error("FAIL %s a.o_ready cyc=%0d got=%b exp=%b", tag, cyc, bus_a.o_ready, ra);
        end
        n_tests++;
        assert (bus_a.o_state === sa) else begin
            n_fail++;
            $error("FAIL %s a.o_state cyc=%0d got=%0d exp=%0d", tag, cyc, bus_a.o_state, sa);
        end
        n_tests++;
        assert (bus_b.o_rst === eb[0:0]) else begin
            n_fail++;
            $error("FAIL %s b.o_rst cyc=%0d got=%b exp=%b", tag, cyc, bus_b.o_rst, eb[0:0]);
        end
        n_tests++;
        assert (bus_b.o_ready === rb) else begin
            n_fail++;
            $error("FAIL %s b.o_ready cyc=%0d got=%b exp=%b", tag, cyc, bus_b.o_ready, rb);
        end
        n_tests++;
        assert (bus_b.o_state === sb) else begin
            n_fail++;
            $error("FAIL %s b.o_state cyc=%0d got=%0d exp=%0d", tag, cyc, bus_b.o_state, sb);
        end
    endtask

    // One clock edge; a request is honoured on a rising edge of the request seen while in RUN.
    task automatic step();
        bit rc;
        int pst;
        rc  = bus_a.i_sw_rst_req;
        pst = st_exp(cyc, t0a, swa, H_A, S_A, N_A);
        @(posedge clk);
        cyc++;
        if (SW_EN && rst_n && rc && !req_prev && pst == 3) begin
            swa = cyc;
            t0a = cyc + SW_A;
        end
        req_prev = rst_n ? rc : 1'b0;
        #1 check_all("step");
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic assert_rst();
        #2 rst_n = 1'b0;
        t0a = -1;
        t0b = -1;
        swa = -1;
        req_prev = 1'b0;
        #1 check_all("async");
    endtask

    // Release lands before the next edge E, so T0 = E + SYNC_STAGES.
    task automatic release_rst();
        #1 rst_n = 1'b1;
        t0a = cyc + 1 + SY_A;
        t0b = cyc + 1 + SY_B;
    endtask

    initial begin
        int kind, wait_n;
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        t0a      = -1;
        t0b      = -1;
        swa      = -1;
        req_prev = 1'b0;
        bus_a.i_sw_rst_req = 1'b0;
        bus_b.i_sw_rst_req = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_all("reset");
        run(3);

        // Basic power-up sequence.
        release_rst();
        run_to(t0a + 45);

        // Reset mid-SEQ, then the identical sequence again.
        assert_rst();
        run(2);
        release_rst();
        run_to(t0a + 19);
        assert_rst();
        run(2);
        release_rst();
        run_to(t0a + 45);

        // Single-cycle software request in RUN.
        bus_a.i_sw_rst_req = 1'b1;
        step();
        bus_a.i_sw_rst_req = 1'b0;
        run_to(t0a + 45);

        // Request held through HOLD/SEQ, then held three cycles in RUN.
        assert_rst();
        release_rst();
        run_to(t0a + 1);
        bus_a.i_sw_rst_req = 1'b1;
        run_to(t0a + 38);
        bus_a.i_sw_rst_req = 1'b0;
        run_to(t0a + 42);
        bus_a.i_sw_rst_req = 1'b1;
        run(3);
        bus_a.i_sw_rst_req = 1'b0;
        run_to(t0a + 45);

        // Randomized mix of glitches, held resets and request pulses.
        for (int it = 0; it < 10; it++) begin
            wait_n = int'($urandom_range(0, 60));
            run(wait_n);
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: begin
                    assert_rst();
                    release_rst();
                end
                1: begin
                    assert_rst();
                    run(int'($urandom_range(1, 3)));
                    release_rst();
                end
                2: begin
                    bus_a.i_sw_rst_req = 1'b1;
                    step();
                    bus_a.i_sw_rst_req = 1'b0;
                end
                default: begin
                    bus_a.i_sw_rst_req = 1'b1;
                    run(int'($urandom_range(1, 4)));
                    bus_a.i_sw_rst_req = 1'b0;
                end
            endcase
            run(int'($urandom_range(5, 20)));
        end
        run_to(t0a + 45);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
